// File: rtl/sb_param_ccff_dbuf.sv
// Corner switch block: right/bottom channel muxes driven by a double-buffered config chain (CCFF_PARITY_EN adds a frame parity bit).
// Latency: routing is combinational; shadow selects commit one prog_clk edge after the final frame bit.
// Backpressure: none; shifting is gated only by ccff_shift, and the live selects hold while the chain is reloaded.
module sb_param_ccff_dbuf #(
    parameter  int CHAN_WIDTH = 5,
    parameter  int NUM_PIN    = 8,
    localparam int SEL_W      = $clog2(NUM_PIN + 1),
    localparam int FRAME_BITS = 2 * CHAN_WIDTH * SEL_W
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [NUM_PIN-1:0]    right_pin_in,
    input  logic [NUM_PIN-1:0]    bottom_pin_in,
    input  logic                  ccff_head,
    input  logic                  ccff_shift,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic                  ccff_tail,
    output logic                  cfg_done,
    output logic                  cfg_err
);

`ifdef CCFF_PARITY_EN
    localparam int SR_W = FRAME_BITS + 1;
`else
    localparam int SR_W = FRAME_BITS;
`endif
    localparam int CNT_W = $clog2(SR_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_W - 1);

    typedef enum logic [1:0] {
        ST_UNCONF,
        ST_LOADING,
        ST_ACTIVE,
        ST_RELOAD
    } state_t;

    state_t                r_state;
    logic [SR_W-1:0]       r_sr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_commit_pend;
    logic [FRAME_BITS-1:0] r_shadow;
    logic                  r_cfg_done;
    logic [FRAME_BITS-1:0] w_payload;
    logic                  w_frame_ok;
    logic                  w_route_en;
    logic [CHAN_WIDTH-1:0] w_right;
    logic [CHAN_WIDTH-1:0] w_bottom;
    logic [SEL_W-1:0]      w_sel_r [CHAN_WIDTH];
    logic [SEL_W-1:0]      w_sel_b [CHAN_WIDTH];

`ifdef CCFF_PARITY_EN
    logic r_cfg_err;

    // Parity is the last bit shifted, so it lands in sr[0]; even parity over the whole frame.
    assign w_payload  = r_sr[SR_W-1:1];
    assign w_frame_ok = ~^r_sr;
    assign cfg_err    = r_cfg_err;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_cfg_err <= 1'b0;
        end else if (r_commit_pend) begin
            r_cfg_err <= ~w_frame_ok;
        end
    end
`else
    assign w_payload  = r_sr;
    assign w_frame_ok = 1'b1;
    assign cfg_err    = 1'b0;
`endif

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state       <= ST_UNCONF;
            r_sr          <= '0;
            r_cnt         <= '0;
            r_commit_pend <= 1'b0;
            r_shadow      <= '0;
            r_cfg_done    <= 1'b0;
        end else begin
            r_commit_pend <= 1'b0;
            if (ccff_shift) begin
                r_sr <= {r_sr[SR_W-2:0], ccff_head};
                if (r_cnt == CNT_LAST) begin
                    r_cnt         <= '0;
                    r_commit_pend <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Commit samples sr one edge after frame end; a continued stream only shifts it afterwards.
            if (r_commit_pend && w_frame_ok) begin
                r_shadow   <= w_payload;
                r_cfg_done <= 1'b1;
            end

            case (r_state)
                ST_UNCONF:  if (ccff_shift) r_state <= ST_LOADING;
                ST_LOADING: if (r_commit_pend && w_frame_ok) r_state <= ST_ACTIVE;
                ST_ACTIVE:  if (ccff_shift) r_state <= ST_RELOAD;
                ST_RELOAD:  if (r_commit_pend && w_frame_ok) r_state <= ST_ACTIVE;
                default:    r_state <= ST_UNCONF;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < CHAN_WIDTH; i++) begin
            w_sel_r[i]  = r_shadow[i*SEL_W +: SEL_W];
            w_sel_b[i]  = r_shadow[(i+CHAN_WIDTH)*SEL_W +: SEL_W];
            w_right[i]  = 1'b0;
            w_bottom[i] = 1'b0;
            if (w_sel_r[i] == '0) w_right[i] = chany_bottom_in[i];
            if (w_sel_b[i] == '0) w_bottom[i] = chanx_right_in[i];
            // Selects beyond NUM_PIN match no pin and leave the track at 0.
            for (int j = 0; j < NUM_PIN; j++) begin
                if (w_sel_r[i] == SEL_W'(j + 1)) w_right[i] = right_pin_in[j];
                if (w_sel_b[i] == SEL_W'(j + 1)) w_bottom[i] = bottom_pin_in[j];
            end
        end
    end

    assign w_route_en       = (r_state == ST_ACTIVE) || (r_state == ST_RELOAD);
    assign chanx_right_out  = w_route_en ? w_right : '0;
    assign chany_bottom_out = w_route_en ? w_bottom : '0;
    assign ccff_tail        = r_sr[SR_W-1];
    assign cfg_done         = r_cfg_done;

endmodule

// File: tb/tb_sb_param_ccff_dbuf.sv
// Bench for sb_param_ccff_dbuf: fixed vectors, corner sequences and a random stream against a bit-queue model.
module tb_sb_param_ccff_dbuf;
    localparam int CW = 5;
    localparam int NP = 8;
    localparam int SW = 4;
    localparam int FB = 40;
`ifdef CCFF_PARITY_EN
    localparam int FL = FB + 1;
`else
    localparam int FL = FB;
`endif

    logic          prog_clk;
    logic          pReset;
    logic [CW-1:0] chanx_right_in, chany_bottom_in;
    logic [NP-1:0] right_pin_in, bottom_pin_in;
    logic          ccff_head, ccff_shift;
    logic [CW-1:0] chanx_right_out, chany_bottom_out;
    logic          ccff_tail, cfg_done, cfg_err;

    sb_param_ccff_dbuf dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .chanx_right_in  (chanx_right_in),
        .chany_bottom_in (chany_bottom_in),
        .right_pin_in    (right_pin_in),
        .bottom_pin_in   (bottom_pin_in),
        .ccff_head       (ccff_head),
        .ccff_shift      (ccff_shift),
        .chanx_right_out (chanx_right_out),
        .chany_bottom_out(chany_bottom_out),
        .ccff_tail       (ccff_tail),
        .cfg_done        (cfg_done),
        .cfg_err         (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: the last FL shifted bits, shift count in the frame, and the committed configuration.
    bit            q[$];
    int            m_cnt;
    bit            m_pend, m_pend_ok, m_done, m_err;
    logic [FB-1:0] m_pend_pay, m_shadow;

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_pend = 0; m_pend_ok = 0; m_done = 0; m_err = 0;
        m_pend_pay = '0; m_shadow = '0;
    endtask

    task automatic model_edge(input logic sh, input logic hd);
        if (m_pend) begin
            if (m_pend_ok) begin
                m_shadow = m_pend_pay; m_done = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
            m_pend = 0;
        end
        if (sh) begin
            q.push_back(hd);
            if (q.size() > FL) q.delete(0);
            m_cnt++;
            if (m_cnt == FL) begin
                m_cnt = 0;
                m_pend = 1;
                for (int t = 0; t < FB; t++) m_pend_pay[FB-1-t] = q[t];
`ifdef CCFF_PARITY_EN
                m_pend_ok = (($countones(m_pend_pay) + int'(q[FB])) % 2) == 0;
`else
                m_pend_ok = 1;
`endif
            end
        end
    endtask

    function automatic logic [CW-1:0] exp_route(input int base, input logic [CW-1:0] opp,
                                                input logic [NP-1:0] pins);
        logic [CW-1:0] r;
        int sel;
        r = '0;
        if (m_done) begin
            for (int i = 0; i < CW; i++) begin
                sel = int'((m_shadow >> ((base + i) * SW)) & 40'hF);
                if (sel == 0) r[i] = opp[i];
                else if (sel <= NP) r[i] = pins[sel-1];
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_model();
        #1;
        chk("right_out", chanx_right_out, exp_route(0, chany_bottom_in, right_pin_in));
        chk("bottom_out", chany_bottom_out, exp_route(CW, chanx_right_in, bottom_pin_in));
        chk("cfg_done", cfg_done, m_done);
        chk("cfg_err", cfg_err, m_err);
        chk("ccff_tail", ccff_tail, (q.size() == FL) ? q[0] : 1'b0);
    endtask

    task automatic step(input logic sh, input logic hd);
        ccff_shift = sh; ccff_head = hd;
        @(posedge prog_clk);
        model_edge(sh, hd);
        @(negedge prog_clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge prog_clk);
        pReset = 1'b0;
        model_reset();
        repeat (2) @(negedge prog_clk);
        ccff_shift = 1'b0;
        pReset = 1'b1;
        check_model();
    endtask

    task automatic shift_bits(input logic [FB-1:0] p, input int from, input int to);
        for (int t = from; t < to; t++) step(1'b1, p[FB-1-t]);
    endtask

    task automatic shift_frame(input logic [FB-1:0] p);
        shift_bits(p, 0, FB);
`ifdef CCFF_PARITY_EN
        step(1'b1, ^p);
`endif
    endtask

    typedef struct {
        logic [CW-1:0] cx, cy;
        logic [NP-1:0] rp, bp;
        logic [CW-1:0] er, eb;
    } vec_t;

    vec_t          tbl[8];
    int            sels[10];
    logic [FB-1:0] pay;
    bit            f1[$];
    logic          b;

    initial begin
        // Right sels 0,1,8,0,9 and bottom sels 0,3,15,0,8.
        tbl[0] = '{5'h1F, 5'h1F, 8'hFF, 8'hFF, 5'h0F, 5'h1B};
        tbl[1] = '{5'h00, 5'h00, 8'h00, 8'h00, 5'h00, 5'h00};
        tbl[2] = '{5'h00, 5'h09, 8'h00, 8'h00, 5'h09, 5'h00};
        tbl[3] = '{5'h09, 5'h00, 8'h00, 8'h00, 5'h00, 5'h09};
        tbl[4] = '{5'h00, 5'h00, 8'h81, 8'h00, 5'h06, 5'h00};
        tbl[5] = '{5'h00, 5'h00, 8'h00, 8'h84, 5'h00, 5'h12};
        tbl[6] = '{5'h00, 5'h00, 8'h7E, 8'h7B, 5'h00, 5'h00};
        tbl[7] = '{5'h04, 5'h00, 8'h00, 8'hFF, 5'h00, 5'h12};
        sels = '{0, 1, 8, 0, 9, 0, 3, 15, 0, 8};

        // Reset with every input high.
        pReset = 1'b0;
        chanx_right_in = '1; chany_bottom_in = '1; right_pin_in = '1; bottom_pin_in = '1;
        ccff_head = 1'b1; ccff_shift = 1'b1;
        model_reset();
        repeat (3) @(negedge prog_clk);
        #1;
        chk("rst_right", chanx_right_out, 0);
        chk("rst_bottom", chany_bottom_out, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_tail", ccff_tail, 0);
        chk("rst_err", cfg_err, 0);
        ccff_shift = 1'b0;
        pReset = 1'b1;

        // All-zero selects: right follows bottom input after the commit edge.
        shift_frame('0);
        chk("t2_pending_done", cfg_done, 0);
        chk("t2_pending_right", chanx_right_out, 0);
        step(1'b0, 1'b0);
        chk("t2_done", cfg_done, 1);
        chanx_right_in = '0; chany_bottom_in = 5'b10101; right_pin_in = '0; bottom_pin_in = '0;
        check_model();
        chk("t2_follow", chanx_right_out, 5'b10101);

        // Half a reload frame then a pause: old routing holds.
        pay = 40'h8;
        chany_bottom_in = 5'b11110; right_pin_in = 8'h80;
        shift_bits(pay, 0, 20);
        repeat (5) step(1'b0, 1'b0);
        chk("t3_hold_right", chanx_right_out, 5'b11110);
        chk("t3_hold_done", cfg_done, 1);
        shift_bits(pay, 20, FB);
`ifdef CCFF_PARITY_EN
        step(1'b1, ^pay);
`endif
        chk("t3_pre_commit", chanx_right_out, 5'b11110);
        step(1'b0, 1'b0);
        chk("t3_pin7_hi", chanx_right_out, 5'b11111);
        right_pin_in = 8'h7F;
        check_model();
        chk("t3_pin7_lo", chanx_right_out, 5'b11110);

        // Fixed vectors over a mixed select frame (includes sel 9 and 15).
        pay = '0;
        for (int k = 0; k < 10; k++) pay[k*SW +: SW] = SW'(sels[k]);
        shift_frame(pay);
        step(1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            chanx_right_in = tbl[v].cx; chany_bottom_in = tbl[v].cy;
            right_pin_in = tbl[v].rp; bottom_pin_in = tbl[v].bp;
            check_model();
            chk("tbl_right", chanx_right_out, tbl[v].er);
            chk("tbl_bottom", chany_bottom_out, tbl[v].eb);
        end

        // Two back-to-back frames: the tail replays the first frame FL shifts later.
        f1.delete();
        for (int n = 1; n <= 2 * FL; n++) begin
            b = 1'($urandom_range(0, 1));
            if (n <= FL) f1.push_back(b);
            step(1'b1, b);
            if (n >= FL && n < 2 * FL) chk("t5_tail_replay", ccff_tail, f1[n-FL]);
        end
        step(1'b0, 1'b0);

        // Random traffic with a model check every cycle.
        for (int c = 0; c < 600; c++) begin
            chanx_right_in = CW'($urandom); chany_bottom_in = CW'($urandom);
            right_pin_in = NP'($urandom); bottom_pin_in = NP'($urandom);
            step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
        end

        // Reset mid-frame discards the partial frame and unconfigures.
        shift_bits(pay, 0, 17);
        do_reset();
        chk("t7_done", cfg_done, 0);
        chk("t7_right", chanx_right_out, 0);
        shift_bits(pay, 0, FB - 1);
        step(1'b0, 1'b0);
        chk("t7_partial_done", cfg_done, 0);

`ifdef CCFF_PARITY_EN
        do_reset();
        shift_frame('0);
        step(1'b0, 1'b0);
        shift_bits(pay, 0, FB);
        step(1'b1, ~(^pay));
        step(1'b0, 1'b0);
        chk("t6_bad_err", cfg_err, 1);
        chk("t6_bad_done", cfg_done, 1);
        shift_frame(pay);
        step(1'b0, 1'b0);
        chk("t6_good_err", cfg_err, 0);
        shift_bits(pay, 0, 9);
        do_reset();
        chk("t6_rst_done", cfg_done, 0);
        chk("t6_rst_err", cfg_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
